// File: rtl/packet_pkg.sv
// Packet type encoding and target-mask classification shared by the switch.
package packet_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    SDP  = 2'd1,
    MDP  = 2'd2,
    BDP  = 2'd3
  } pkt_type_e;

  localparam int MAX_PORTS = 16;

  // Only the low num_ports bits of the target are meaningful.
  function automatic pkt_type_e classify(input logic [MAX_PORTS-1:0] target,
                                         input int num_ports);
    int ones;
    ones = 0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      if (k < num_ports && target[k]) ones = ones + 1;
    end
    if (ones == 0)              return NONE;
    else if (ones == num_ports) return BDP;
    else if (ones == 1)         return SDP;
    else                        return MDP;
  endfunction

endpackage

// File: rtl/switch_rr_arbiter.sv
// N-way round-robin arbiter: the pointer names the highest-priority requester,
// priority then rotates upward modulo N. Grant is one-hot or zero.
module switch_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o
);

  localparam int PW = $clog2(N);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_nport.sv
// Parametrised N-port packet switch: per-input ingress FIFOs whose head keeps a
// live pending mask, and one round-robin arbiter plus output register per port.
module switch_nport
  import packet_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] valid_in,
  output logic [NUM_PORTS-1:0] ready_in,
  input  logic [NUM_PORTS-1:0] source_in [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] target_in [NUM_PORTS],
  input  logic [DATA_W-1:0]    data_in   [NUM_PORTS],
  output logic [NUM_PORTS-1:0] valid_out,
  input  logic [NUM_PORTS-1:0] ready_out,
  output logic [NUM_PORTS-1:0] source_out [NUM_PORTS],
  output logic [DATA_W-1:0]    data_out   [NUM_PORTS],
  output pkt_type_e            type_out   [NUM_PORTS],
  output logic [NUM_PORTS-1:0] drop
);

  localparam int N  = NUM_PORTS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(NUM_PORTS);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [N-1:0] PORT0    = N'(1);

  typedef struct packed {
    logic [N-1:0]      src;
    logic [DATA_W-1:0] data;
    pkt_type_e         typ;
    logic [N-1:0]      mask;
  } entry_t;

  entry_t       mem_q [N][FIFO_DEPTH];
  logic [AW:0]  wr_ptr_q [N];
  logic [AW:0]  rd_ptr_q [N];
  logic [N-1:0] served_q [N];
  logic [N-1:0] served_d [N];
  logic [N-1:0] drop_q;

  entry_t       new_entry [N];
  entry_t       head      [N];
  logic [N-1:0] eff_mask  [N];
  logic [N-1:0] pending   [N];
  logic [N-1:0] gnt_in    [N];
  logic [N-1:0] empty, full, accept, push, pop;

  logic [N-1:0]      req     [N];
  logic [N-1:0]      arb_gnt [N];
  logic [N-1:0]      gnt     [N];
  logic [N-1:0]      load;
  logic [PW-1:0]     rr_q    [N];
  logic [PW-1:0]     rr_d    [N];
  logic [N-1:0]      valid_q;
  logic [N-1:0]      src_q   [N];
  logic [DATA_W-1:0] data_q  [N];
  pkt_type_e         typ_q   [N];
  logic [N-1:0]      sel_src [N];
  logic [DATA_W-1:0] sel_data[N];
  pkt_type_e         sel_typ [N];

  for (genvar i = 0; i < N; i++) begin : g_in
    assign empty[i]     = (wr_ptr_q[i] == rd_ptr_q[i]);
    assign full[i]      = ((wr_ptr_q[i] - rd_ptr_q[i]) == FULL_CNT);
    assign accept[i]    = valid_in[i] && !full[i];
    assign eff_mask[i]  = target_in[i] & ~(PORT0 << i);
    assign push[i]      = accept[i] && (eff_mask[i] != '0);
    assign new_entry[i] = {source_in[i], data_in[i],
                           classify(MAX_PORTS'(target_in[i]), N), eff_mask[i]};
    assign head[i]      = mem_q[i][rd_ptr_q[i][AW-1:0]];
    // Bits already served by earlier grants are masked off the stored mask.
    assign pending[i]   = empty[i] ? '0 : (head[i].mask & ~served_q[i]);
    assign pop[i]       = !empty[i] && ((pending[i] & ~gnt_in[i]) == '0);
  end

  assign ready_in = ~full;
  assign drop     = drop_q;

  always_comb begin
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        req[o][i]    = pending[i][o];
        gnt_in[i][o] = gnt[o][i];
      end
    end
    for (int i = 0; i < N; i++) begin
      served_d[i] = pop[i] ? '0 : (served_q[i] | gnt_in[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
      for (int i = 0; i < N; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        served_q[i] <= '0;
      end
    end else begin
      drop_q <= accept & ~push;
      for (int i = 0; i < N; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        served_q[i] <= served_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= new_entry[i];
    end
  end

  for (genvar o = 0; o < N; o++) begin : g_out
    assign load[o] = !valid_q[o] || ready_out[o];
    switch_rr_arbiter #(.N(N)) u_arb (
      .req_i  (req[o]),
      .ptr_i  (rr_q[o]),
      .grant_o(arb_gnt[o])
    );
    assign gnt[o] = load[o] ? arb_gnt[o] : '0;
  end

  always_comb begin
    for (int o = 0; o < N; o++) begin
      sel_src[o]  = '0;
      sel_data[o] = '0;
      sel_typ[o]  = NONE;
      rr_d[o]     = rr_q[o];
      for (int i = 0; i < N; i++) begin
        if (gnt[o][i]) begin
          sel_src[o]  = head[i].src;
          sel_data[o] = head[i].data;
          sel_typ[o]  = head[i].typ;
          rr_d[o]     = PW'((i + 1) % N);
        end
      end
    end
  end

  // A freed output reloads in the same edge it hands off, so no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int o = 0; o < N; o++) begin
        src_q[o]  <= '0;
        data_q[o] <= '0;
        typ_q[o]  <= NONE;
        rr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < N; o++) begin
        if (gnt[o] != '0) begin
          valid_q[o] <= 1'b1;
          src_q[o]   <= sel_src[o];
          data_q[o]  <= sel_data[o];
          typ_q[o]   <= sel_typ[o];
          rr_q[o]    <= rr_d[o];
        end else if (ready_out[o]) begin
          valid_q[o] <= 1'b0;
        end
      end
    end
  end

  assign valid_out  = valid_q;
  assign source_out = src_q;
  assign data_out   = data_q;
  assign type_out   = typ_q;

endmodule

// File: tb/tb_switch_nport.sv
// Self-checking bench for switch_nport: directed scenarios plus randomized
// traffic scored against per input/output-pair expectation queues.
module tb_switch_nport;
  import packet_pkg::*;

  localparam int N = 4;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  valid_in, ready_in, valid_out, ready_out, drop;
  logic [N-1:0]  source_in [N];
  logic [N-1:0]  target_in [N];
  logic [DW-1:0] data_in   [N];
  logic [N-1:0]  source_out[N];
  logic [DW-1:0] data_out  [N];
  pkt_type_e     type_out  [N];

  int checks = 0;
  int errors = 0;
  logic [13:0] sbq [N*N][$];
  logic [N-1:0] pendDrop = '0;

  switch_nport #(.NUM_PORTS(N), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .ready_in(ready_in),
    .source_in(source_in), .target_in(target_in), .data_in(data_in),
    .valid_out(valid_out), .ready_out(ready_out),
    .source_out(source_out), .data_out(data_out), .type_out(type_out),
    .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [1:0] modelType(input logic [N-1:0] t);
    int ones;
    ones = $countones(t);
    if (ones == 0) return 2'd0;
    if (t == '1)   return 2'd3;
    if (ones == 1) return 2'd1;
    return 2'd2;
  endfunction

  function automatic int sbTotal();
    int s;
    s = 0;
    for (int k = 0; k < N*N; k++) s += sbq[k].size();
    return s;
  endfunction

  task automatic modelAccept(input int i);
    logic [N-1:0] eff;
    eff = target_in[i] & ~(4'b0001 << i);
    if (eff == '0) pendDrop[i] = 1'b1;
    else
      for (int o = 0; o < N; o++)
        if (eff[o]) sbq[i*N+o].push_back({source_in[i], data_in[i], modelType(target_in[i])});
  endtask

  task automatic modelDeliver(input int o);
    logic [13:0] pkt;
    logic found;
    pkt = {source_out[o], data_out[o], 2'(type_out[o])};
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && sbq[i*N+o].size() > 0 && sbq[i*N+o][0] == pkt) begin
        void'(sbq[i*N+o].pop_front());
        found = 1'b1;
      end
    end
    if (!found) $display("[TB] unexpected delivery on out%0d: pkt %0h", o, pkt);
    checkOutput($sformatf("deliver%0d", o), found, 1);
  endtask

  task automatic flushModel();
    for (int k = 0; k < N*N; k++) sbq[k].delete();
    pendDrop = '0;
  endtask

  task automatic clearInputs();
    valid_in = '0;
    for (int i = 0; i < N; i++) begin
      target_in[i] = '0;
      source_in[i] = '0;
      data_in[i]   = '0;
    end
  endtask

  task automatic applyStimulus(input int port, input logic [N-1:0] tgt,
                               input logic [DW-1:0] dat, input logic [N-1:0] src);
    valid_in[port]  = 1'b1;
    target_in[port] = tgt;
    data_in[port]   = dat;
    source_in[port] = src;
  endtask

  // Handshakes are scored before the edge; outputs are checked at the next negedge.
  task automatic tick();
    for (int i = 0; i < N; i++) if (valid_in[i] && ready_in[i]) modelAccept(i);
    for (int o = 0; o < N; o++) if (valid_out[o] && ready_out[o]) modelDeliver(o);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) checkOutput($sformatf("drop%0d", i), drop[i], pendDrop[i]);
    pendDrop = '0;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    clearInputs();
    flushModel();
    ready_out = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_valid", valid_out, 0);
    checkOutput("rst_ready", ready_in, 4'hF);
    checkOutput("rst_drop", drop, 0);
    checkOutput("rst_data2", data_out[2], 0);
    checkOutput("rst_type3", type_out[3], NONE);
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    ready_out = '1;

    // SDP single hop, minimum latency
    resetDut();
    applyStimulus(0, 4'b0010, 8'hA1, 4'b0001);
    tick();
    clearInputs();
    checkOutput("sdp_lat0", valid_out, 0);
    tick();
    checkOutput("sdp_valid", valid_out, 4'b0010);
    checkOutput("sdp_data", data_out[1], 8'hA1);
    checkOutput("sdp_type", type_out[1], SDP);
    checkOutput("sdp_src", source_out[1], 4'b0001);
    tick();
    checkOutput("sdp_done", valid_out, 0);

    // Broadcast with loopback suppression, then head must have popped
    resetDut();
    applyStimulus(0, 4'b1111, 8'hA3, 4'b0001);
    tick();
    clearInputs();
    tick();
    checkOutput("bdp_valid", valid_out, 4'b1110);
    for (int o = 1; o < N; o++) begin
      checkOutput("bdp_data", data_out[o], 8'hA3);
      checkOutput("bdp_type", type_out[o], BDP);
    end
    applyStimulus(0, 4'b0100, 8'hA4, 4'b0001);
    tick();
    clearInputs();
    checkOutput("bdp_after", valid_out, 0);
    tick();
    checkOutput("bdp_next_v", valid_out, 4'b0100);
    checkOutput("bdp_next_d", data_out[2], 8'hA4);

    // Contention on output 3, round-robin order
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(i, 4'b1000, 8'hC0 + 8'(i), 4'(1 << i));
    tick();
    clearInputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("rr_valid", valid_out[3], 1);
      checkOutput("rr_data", data_out[3], 8'hC0 + 8'(k));
    end
    applyStimulus(2, 4'b1000, 8'hD2, 4'b0100);
    applyStimulus(0, 4'b1000, 8'hD0, 4'b0001);
    tick();
    clearInputs();
    tick();
    checkOutput("rr_wrap_d", data_out[3], 8'hD0);
    checkOutput("rr_wrap_s", source_out[3], 4'b0001);
    tick();
    checkOutput("rr_wrap_d2", data_out[3], 8'hD2);

    // Backpressure fills FIFO0 plus the output register
    resetDut();
    ready_out = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_rdy", ready_in[0], 1);
      applyStimulus(0, 4'b0010, 8'h40 + 8'(k), 4'b0001);
      tick();
    end
    applyStimulus(0, 4'b0010, 8'h45, 4'b0001);
    checkOutput("bp_full", ready_in[0], 0);
    tick();
    tick();
    checkOutput("bp_full2", ready_in[0], 0);
    checkOutput("bp_hold_v", valid_out[1], 1);
    checkOutput("bp_hold_d", data_out[1], 8'h40);
    ready_out = '1;
    for (int k = 1; k <= 5; k++) begin
      logic acc;
      acc = valid_in[0] && ready_in[0];
      tick();
      if (acc) valid_in[0] = 1'b0;
      checkOutput("bp_valid", valid_out[1], 1);
      checkOutput("bp_data", data_out[1], 8'h40 + 8'(k));
    end
    tick();
    checkOutput("bp_empty", valid_out[1], 0);

    // Partial multicast with head-of-line blocking
    resetDut();
    ready_out = 4'b1011;
    applyStimulus(3, 4'b0100, 8'h33, 4'b1000);
    tick();
    clearInputs();
    tick();
    applyStimulus(1, 4'b0101, 8'hB2, 4'b0010);
    tick();
    clearInputs();
    applyStimulus(1, 4'b0001, 8'hB3, 4'b0010);
    tick();
    clearInputs();
    checkOutput("mdp_v0", valid_out[0], 1);
    checkOutput("mdp_d0", data_out[0], 8'hB2);
    checkOutput("mdp_t0", type_out[0], MDP);
    checkOutput("mdp_d2_hold", data_out[2], 8'h33);
    tick();
    checkOutput("mdp_block1", valid_out[0], 0);
    tick();
    checkOutput("mdp_block2", valid_out[0], 0);
    ready_out = '1;
    tick();
    checkOutput("mdp_d2", data_out[2], 8'hB2);
    checkOutput("mdp_t2", type_out[2], MDP);
    tick();
    checkOutput("mdp_next_v", valid_out[0], 1);
    checkOutput("mdp_next_d", data_out[0], 8'hB3);
    checkOutput("mdp_next_t", type_out[0], SDP);

    // Drops: self-only and empty targets
    resetDut();
    applyStimulus(0, 4'b0001, 8'h55, 4'b0001);
    applyStimulus(2, 4'b0000, 8'h56, 4'b0100);
    tick();
    clearInputs();
    checkOutput("drop_pulse", drop, 4'b0101);
    tick();
    checkOutput("drop_clear", drop, 0);
    checkOutput("drop_noout", valid_out, 0);

    // Reset in the middle of traffic
    ready_out = '0;
    applyStimulus(0, 4'b0110, 8'h60, 4'b0001);
    applyStimulus(1, 4'b1000, 8'h61, 4'b0010);
    applyStimulus(3, 4'b0001, 8'h63, 4'b1000);
    tick();
    clearInputs();
    applyStimulus(2, 4'b0001, 8'h62, 4'b0100);
    tick();
    clearInputs();
    checkOutput("mid_full", valid_out, 4'b1111);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_v", valid_out, 0);
    flushModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ready_out = '1;
    checkOutput("mid_rdy", ready_in, 4'hF);
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput("mid_quiet", valid_out, 0);
    end

    // Randomized traffic
    resetDut();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        valid_in[i]  = ($urandom_range(0, 2) != 0);
        target_in[i] = 4'($urandom);
        source_in[i] = 4'($urandom);
        data_in[i]   = 8'($urandom);
        ready_out[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    clearInputs();
    ready_out = '1;
    for (int c = 0; c < 100 && (sbTotal() != 0 || valid_out != '0); c++) tick();
    checkOutput("drain_left", sbTotal(), 0);
    checkOutput("drain_valid", valid_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_nport.md
# switch_nport

Parametrised N-port packet switch with per-input ingress FIFOs and per-output round-robin arbitration. It is the successor to the fixed 4-port switch. It keeps the SDP/MDP/BDP target-mask semantics and adds generic port count, data width and FIFO depth. It also adds ready/valid backpressure on both sides, independent per-copy multicast delivery, loopback suppression and an explicit drop indication. It sits between the port-facing logic and the packet sinks, one instance per switch fabric.

## Interface
- NUM_PORTS, 4, number of ports N (2..16).
- DATA_W, 8, payload width.
- FIFO_DEPTH, 4, ingress FIFO entries per input (power of 2, ≥2).

Ports (arrays are indexed by port, [NUM_PORTS]):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  [N]x1  input packet valid.
- ready_in  out  [N]x1  input can accept; equals !fifo_full.
- source_in  in  [N]xN  source mask, carried through unmodified.
- target_in  in  [N]xN  destination mask, bit k = output k.
- data_in  in  [N]xDATA_W  payload.
- valid_out  out  [N]x1  output packet valid.
- ready_out  in  [N]x1  sink accepts.
- source_out  out  [N]xN  source mask of the delivered packet.
- data_out  out  [N]xDATA_W  payload.
- type_out  out  [N]x2  pkt_type_e of the delivered packet.
- drop  out  [N]x1  one-cycle pulse: input i discarded a packet.

## Operation
- Accept on input i when valid_in[i] && ready_in[i] at a rising edge.
- Classification uses the raw target:
  - all ones → BDP;
  - popcount 1 → SDP;
  - popcount ≥ 2 and not all ones → MDP;
  - zero → NONE.
- Effective mask = target & ~(1<<i), so loopback is never delivered.
- If the effective mask is 0 (NONE, or self-only), the packet is not written. drop[i] pulses in the cycle after acceptance.
- Otherwise push {source, data, type, effective mask} into FIFO i.
- The FIFO head carries a live pending mask, initialised to the effective mask.
- Output arbitration, per output o:
  - Requesters are the inputs whose head pending mask has bit o set.
  - Output o may load when !valid_out[o] || ready_out[o].
  - The round-robin pointer rr[o] gives highest priority to input rr[o], then rr[o]+1 mod N, and so on.
  - On a grant to input i: the output register loads the packet, bit o of head i is cleared, and rr[o] = (i+1) mod N.
- Multicast copies are delivered independently, each as soon as its output is free. The head pops in the cycle its pending mask reaches 0; until then it blocks input i (head-of-line).
- An input can be granted by several outputs in the same cycle. All granted bits clear together.
- ready_in ignores any same-cycle pop: a full FIFO rejects even while popping.
- Per-output delivery order is the arbitration order. Each input-output pair is FIFO-ordered.

## Timing
- Reset (async assert, sync deassert by the system) forces:
  - valid_out 0, data_out/source_out 0, type_out NONE, drop 0;
  - FIFOs empty, so ready_in = 1 after reset;
  - rr[o] = 0.
- Asserting reset mid-operation discards all queued and in-flight packets. Nothing is emitted afterwards.
- Minimum latency: accepted at edge E → valid_out high from edge E+1 (arbitration reads the head combinationally).
- valid_out/data_out stay stable while ready_out is low. There is no bubble between back-to-back grants.
- Full: with FIFO_DEPTH entries stored, ready_in is 0 until a pop.
- FIFO pointers are log2(DEPTH)+1 bits wide and wrap naturally.

## Structure
- The pkt_type_e enum (NONE=0, SDP=1, MDP=2, BDP=3) and the classification function go in packet_pkg.
- Sub-module switch_rr_arbiter: parametrised N-way round-robin with request vector, pointer and one-hot grant. One instance per output.
- The FIFO is inline storage with a pending-mask register per input.

## Test plan
All scenarios use N=4, DATA_W=8, DEPTH=4.
1. SDP: port0 sends target 0010, data A1 → valid_out[1] at E+1 with data A1, type SDP, source 0001. Other outputs stay idle.
2. BDP: port0 sends target 1111, data A3 → ports 1, 2, 3 each output A3 with type BDP at E+1. Port0 stays silent. FIFO0 is empty at E+2.
3. Contention: ports 0, 1, 2 send C0, C1, C2 to port3 at the same edge → port3 outputs C0, C1, C2 on consecutive cycles and rr[3]=3. Ports 2 and 0 then send together → port0's packet wins.
4. Backpressure: ready_out[1]=0 while port0 sends 5 packets to port1 → ready_in[0] drops after the 5th accept and the 6th is held off. Releasing ready_out → data appears in order, one per cycle.
5. Partial MDP: ready_out[2]=0 while port1 sends target 0101, data B2 → port0 gets B2 at E+1. FIFO1 holds the packet, and the next packet queued behind it is blocked. Releasing ready_out[2] → port2 gets B2, then the head pops.
6. Drop/reset: port0 sends target 0001 → drop[0] pulses and there is no output. Asserting rst_n=0 with packets queued → all valid_out go to 0 immediately and nothing emerges after release.
